dcache_ctrl: RTL and testbench
==============================

# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache controller that answers the CPU's MEM-stage load/store requests and fills or evicts lines from a slower line-wide memory. It replaces the CPU's single-cycle data memory port. The CPU side gets a zero-latency response on a hit and a stall signal on a miss. The memory side uses a request/acknowledge handshake.

## Interface
- NUM_LINES, 16, number of cache lines; power of two; index width = log2(NUM_LINES).
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- cpu_req_i  input  1  MEM-stage access valid (MemRead or MemWrite).
- cpu_we_i  input  1  1 = store, 0 = load.
- cpu_addr_i  input  32  byte address; [1:0] ignored (word accesses only).
- cpu_data_i  input  32  store data.
- cpu_data_o  output  32  load data; valid in any cycle with cpu_req_i=1 and cpu_stall_o=0.
- cpu_stall_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB while high.
- mem_req_o  output  1  memory transaction request.
- mem_we_o  output  1  1 = line write-back, 0 = line fill.
- mem_addr_o  output  32  line-aligned address ([4:0] = 0).
- mem_data_o  output  256  write-back line.
- mem_ack_i  input  1  one-cycle pulse; the transaction is complete.
- mem_data_i  input  256  fill line; valid in the mem_ack_i cycle.

## Operation
- Address split: word select [4:2], index [4+log2(NUM_LINES):5], tag = remaining upper bits (23 bits at the default).
- Storage per line: valid, dirty, tag, and 256-bit data. Word w occupies data[32w+31:32w].
- Hit: valid and stored tag equals the address tag.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE, cpu_req_i=0: no action. cpu_stall_o=0.
- IDLE, hit, load: cpu_data_o = selected word (combinational). cpu_stall_o=0.
- IDLE, hit, store: the selected word is replaced by cpu_data_i at the clock edge, and dirty is set to 1. cpu_stall_o=0.
- IDLE, miss: cpu_stall_o=1 combinationally.
  - If the victim line is valid and dirty, next state is WRITEBACK.
  - Otherwise next state is ALLOCATE.
- WRITEBACK:
  - Outputs: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o = victim line.
  - On mem_ack_i: go to ALLOCATE.
- ALLOCATE:
  - Outputs: mem_req_o=1, mem_we_o=0, mem_addr_o={request tag, index, 5'b0}.
  - On mem_ack_i: install mem_data_i, write the tag, set valid=1 and dirty=0, go to IDLE.
- The request is then served as a hit in IDLE. A store merges cpu_data_i and sets dirty at that point.
- cpu_stall_o = (state != IDLE) | (cpu_req_i & miss).
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1. The controller latches nothing from the CPU side.
- mem_ack_i outside WRITEBACK or ALLOCATE is ignored.
- The data array is not reset. Only valid, dirty and the state are cleared.

## Timing
- Reset values (asynchronous): state=IDLE, all valid=0, all dirty=0, mem_req_o=0, mem_we_o=0, cpu_stall_o=0. mem_addr_o, mem_data_o and cpu_data_o are don't-care.
- Hit latency: 0 cycles. A store hit updates the array at the edge closing the MEM cycle.
- mem_req_o rises in the cycle after miss detection.
- mem_req_o holds with stable address and data until the mem_ack_i cycle. An ack in the first request cycle is legal.
- After a WRITEBACK ack, mem_req_o stays high into ALLOCATE. mem_we_o and mem_addr_o change at that edge. Each ack completes exactly one transaction.
- After an ALLOCATE ack, mem_req_o=0 and cpu_stall_o=0 in the next cycle, which is the hit cycle.
- Clean miss with ack N cycles after request: the stall lasts N+2 cycles.
- Dirty miss with acks N1 and N2 cycles after their requests: the stall lasts N1+N2+3 cycles.
- Reset mid-transaction: the transaction is abandoned and mem_req_o drops asynchronously. A late ack after reset is ignored.

## Test plan
- Cold load miss:
  - Stimulus: after reset, load 0x0000_0004. Memory acks 3 cycles after request with word1=0xDEADBEEF.
  - Response: cpu_stall_o high for 5 cycles; one request with mem_req_o=1, mem_we_o=0, mem_addr_o=0x0000_0000. Then cpu_data_o=0xDEADBEEF with stall low and no further mem_req_o.
- Store hit:
  - Stimulus: store 0x1234_5678 to 0x0000_0004, then load 0x0000_0004.
  - Response: no stall on either access; the load returns 0x1234_5678.
- Dirty conflict miss:
  - Stimulus: load 0x0000_0204 (index 0, different tag).
  - Response: WRITEBACK request with mem_we_o=1, mem_addr_o=0x0000_0000, mem_data_o[63:32]=0x1234_5678. After its ack, ALLOCATE request with mem_addr_o=0x0000_0200. After that ack, the filled word is returned.
- Clean conflict miss:
  - Stimulus: load 0x0000_0000 next.
  - Response: ALLOCATE only, no write-back request.
- Zero-wait memory:
  - Stimulus: memory acks in the first request cycle of a clean miss.
  - Response: stall exactly 2 cycles; data correct.
- Reset during ALLOCATE:
  - Stimulus: assert rst_i=0 mid-fill.
  - Response: mem_req_o and cpu_stall_o go low immediately. After release, a load of the previously cached 0x0000_0004 misses.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller sitting between the
// CPU MEM stage (zero-latency hits, stall on miss) and a line-wide request/ack memory.
module dcache_ctrl #(
  parameter int NUM_LINES = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic         mem_ack_i,
  input  logic [255:0] mem_data_i
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 27 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state, state_next;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [255:0]         data_mem [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [2:0]       word;
  logic [TAG_W-1:0] req_tag;
  logic [7:0]       word_lsb;
  logic [255:0]     line;
  logic             hit;
  logic             fill_done;
  logic             store_hit;
  logic             unused_byte_offset;

  assign word     = cpu_addr_i[4:2];
  assign idx      = cpu_addr_i[5 +: IDX_W];
  assign req_tag  = cpu_addr_i[31 -: TAG_W];
  assign word_lsb = {word, 5'b0};
  assign line     = data_mem[idx];
  assign unused_byte_offset = ^cpu_addr_i[1:0];

  assign hit        = valid[idx] && (tag_mem[idx] == req_tag);
  assign fill_done  = (state == ALLOCATE) && mem_ack_i;
  assign store_hit  = (state == IDLE) && cpu_req_i && cpu_we_i && hit;
  assign cpu_data_o = line[word_lsb +: 32];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_next;
      if (fill_done) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (store_hit) begin
        dirty[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies their contents.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      data_mem[idx] <= mem_data_i;
      tag_mem[idx]  <= req_tag;
    end else if (store_hit) begin
      data_mem[idx][word_lsb +: 32] <= cpu_data_i;
    end
  end

  always_comb begin
    state_next  = state;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {req_tag, idx, 5'b0};
    mem_data_o  = line;
    case (state)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          cpu_stall_o = 1'b1;
          state_next  = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_mem[idx], idx, 5'b0};
        if (mem_ack_i) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        if (mem_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a vector table of hit accesses plus hand-written
// miss, write-back, zero-wait and reset-abort sequences against a tiny memory responder.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_ack_i;
  logic [255:0] mem_data_i;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.NUM_LINES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic        chk_data;
    logic [31:0] exp_data;
    string       name;
  } vec_t;

  int compared = 0;
  int mismatched = 0;

  int           stall_cnt, wb_cnt, al_cnt;
  logic [31:0]  wb_addr, al_addr, read_data;
  logic [255:0] wb_data;
  logic         late_req;

  logic [255:0] line_a, line_a_dirty, line_b, line_d, line_e;

  function automatic logic [255:0] makeLine(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = base + w;
    return l;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One CPU access held until the stall drops; the responder acks each memory
  // transaction after the requested number of request cycles (0 = first cycle).
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input int wb_delay, input int al_delay, input logic [255:0] fill,
                               input string name);
    int age;
    bit done;
    stall_cnt = 0; wb_cnt = 0; al_cnt = 0;
    wb_addr = '1; al_addr = '1; wb_data = '0; read_data = '0; late_req = 1'b0;
    age = 0; done = 1'b0;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = wdata;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (!cpu_stall_o) begin
        done = 1'b1;
        read_data = cpu_data_o;
        late_req = mem_req_o;
      end else begin
        stall_cnt++;
        if (mem_req_o) begin
          if (mem_we_o) begin
            wb_addr = mem_addr_o;
            wb_data = mem_data_o;
          end else begin
            al_addr = mem_addr_o;
          end
          if (age == (mem_we_o ? wb_delay : al_delay)) begin
            mem_ack_i = 1'b1;
            mem_data_i = fill;
            age = 0;
            if (mem_we_o) wb_cnt++; else al_cnt++;
          end else begin
            age++;
          end
        end
        @(posedge clk_i);
        #1;
        mem_ack_i = 1'b0;
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s timeout: stall still high after %0d cycles, required low", name, stall_cnt);
    end
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
    cpu_we_i = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    line_a = makeLine(32'h1000_0000);
    line_a[63:32] = 32'hDEAD_BEEF;
    line_a_dirty = line_a;
    line_a_dirty[63:32] = 32'h1234_5678;
    line_a_dirty[255:224] = 32'hCAFE_F00D;
    line_b = makeLine(32'hB000_0000);
    line_d = makeLine(32'hD000_0000);
    line_e = makeLine(32'hE000_0000);

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, 1'b0, 32'h0, "store w1"};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 1'b1, 32'h1234_5678, "load w1"};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h1000_0000, "load w0"};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_001C, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, "store w7"};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_001C, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D, "load w7"};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'h1000_0002, "load w2"};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0204, 32'h0,         1'b0, 1'b0, 32'h0, "idle"};
    vecs[7] = '{1'b1, 1'b0, 32'h0000_0007, 32'h0,         1'b0, 1'b1, 32'h1234_5678, "load byteoff"};

    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    #12;
    checkOutput("reset stall", {31'b0, cpu_stall_o}, 32'd0);
    checkOutput("reset mem_req", {31'b0, mem_req_o}, 32'd0);
    checkOutput("reset mem_we", {31'b0, mem_we_o}, 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 0, 3, line_a, "cold miss");
    checkOutput("cold stall cycles", stall_cnt, 32'd5);
    checkOutput("cold fills", al_cnt, 32'd1);
    checkOutput("cold writebacks", wb_cnt, 32'd0);
    checkOutput("cold fill addr", al_addr, 32'h0000_0000);
    checkOutput("cold data", read_data, 32'hDEAD_BEEF);
    checkOutput("cold req after", {31'b0, late_req}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      cpu_req_i = vecs[i].req; cpu_we_i = vecs[i].we;
      cpu_addr_i = vecs[i].addr; cpu_data_i = vecs[i].wdata;
      #1;
      checkOutput({vecs[i].name, " stall"}, {31'b0, cpu_stall_o}, {31'b0, vecs[i].exp_stall});
      checkOutput({vecs[i].name, " mem_req"}, {31'b0, mem_req_o}, 32'd0);
      if (vecs[i].chk_data) checkOutput({vecs[i].name, " data"}, cpu_data_o, vecs[i].exp_data);
      @(posedge clk_i);
      #1;
    end
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;

    applyStimulus(1'b0, 32'h0000_0204, 32'h0, 1, 2, line_b, "dirty miss");
    checkOutput("dirty stall cycles", stall_cnt, 32'd6);
    checkOutput("dirty writebacks", wb_cnt, 32'd1);
    checkOutput("dirty wb addr", wb_addr, 32'h0000_0000);
    for (int w = 0; w < 8; w++)
      checkOutput($sformatf("dirty wb word%0d", w), wb_data[32*w +: 32], line_a_dirty[32*w +: 32]);
    checkOutput("dirty fills", al_cnt, 32'd1);
    checkOutput("dirty fill addr", al_addr, 32'h0000_0200);
    checkOutput("dirty data", read_data, 32'hB000_0001);

    applyStimulus(1'b0, 32'h0000_0000, 32'h0, 0, 1, line_a_dirty, "clean miss");
    checkOutput("clean stall cycles", stall_cnt, 32'd3);
    checkOutput("clean writebacks", wb_cnt, 32'd0);
    checkOutput("clean fill addr", al_addr, 32'h0000_0000);
    checkOutput("clean data", read_data, 32'h1000_0000);

    applyStimulus(1'b0, 32'h0000_0404, 32'h0, 0, 0, line_d, "zero wait");
    checkOutput("zero wait stall cycles", stall_cnt, 32'd2);
    checkOutput("zero wait fill addr", al_addr, 32'h0000_0400);
    checkOutput("zero wait data", read_data, 32'hD000_0001);

    applyStimulus(1'b1, 32'h0000_0028, 32'h55AA_33CC, 0, 0, line_e, "store miss");
    checkOutput("store miss stall cycles", stall_cnt, 32'd2);
    checkOutput("store miss fill addr", al_addr, 32'h0000_0020);
    applyStimulus(1'b0, 32'h0000_0028, 32'h0, 0, 0, line_e, "merged load");
    checkOutput("merged stall cycles", stall_cnt, 32'd0);
    checkOutput("merged data", read_data, 32'h55AA_33CC);
    applyStimulus(1'b0, 32'h0000_0024, 32'h0, 0, 0, line_e, "neighbour load");
    checkOutput("neighbour data", read_data, 32'hE000_0001);
    applyStimulus(1'b0, 32'h0000_0228, 32'h0, 0, 0, line_b, "evict merged");
    checkOutput("evict stall cycles", stall_cnt, 32'd3);
    checkOutput("evict writebacks", wb_cnt, 32'd1);
    checkOutput("evict wb addr", wb_addr, 32'h0000_0020);
    checkOutput("evict wb word2", wb_data[95:64], 32'h55AA_33CC);
    checkOutput("evict wb word3", wb_data[127:96], 32'hE000_0003);

    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0044;
    #1;
    checkOutput("abort miss stall", {31'b0, cpu_stall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    checkOutput("abort fill req", {31'b0, mem_req_o}, 32'd1);
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    cpu_req_i = 1'b0;
    #1;
    checkOutput("abort req drop", {31'b0, mem_req_o}, 32'd0);
    checkOutput("abort stall drop", {31'b0, cpu_stall_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    mem_ack_i = 1'b1;
    @(posedge clk_i);
    #1;
    mem_ack_i = 1'b0;
    checkOutput("late ack req", {31'b0, mem_req_o}, 32'd0);
    checkOutput("late ack stall", {31'b0, cpu_stall_o}, 32'd0);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, 0, 1, line_a, "post reset");
    checkOutput("post reset stall cycles", stall_cnt, 32'd3);
    checkOutput("post reset writebacks", wb_cnt, 32'd0);
    checkOutput("post reset fill addr", al_addr, 32'h0000_0000);
    checkOutput("post reset data", read_data, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
